instruction_dispatcher: RTL
===========================

INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of queued 15-bit instructions (power of 2, 2..16).
REQ-002 Parameter: TIMEOUT_CYCLES, 1024, cycles allowed in WAIT_DONE before timeout (used only with CMD_TIMEOUT_EN).
REQ-003 Port: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: instruction_in  in  15  received word; [14:12] opcode, [11:0] operand.
REQ-006 Port: instruction_valid  in  1  one-cycle strobe qualifying instruction_in (driven by uart_instruction_handler instruction_ready).
REQ-007 Port: exec_opcode  out  3  opcode of the instruction being issued.
REQ-008 Port: exec_operand  out  12  operand of the instruction being issued.
REQ-009 Port: exec_valid  out  1  issue request to the execution unit.
REQ-010 Port: exec_ready  in  1  execution unit accepts the issue when high with exec_valid.
REQ-011 Port: exec_done  in  1  one-cycle completion strobe from the execution unit.
REQ-012 Port: fifo_count  out  5  number of queued entries (0..FIFO_DEPTH).
REQ-013 Port: busy  out  1  high when state is not IDLE or fifo_count is non-zero.
REQ-014 Port: overflow  out  1  sticky flag: an instruction was dropped because the queue was full.
REQ-015 Port: timeout_err  out  1  sticky flag: exec_done did not arrive within TIMEOUT_CYCLES.

Function
REQ-016 Push: instruction_valid high at edge N writes instruction_in to the FIFO tail; fifo_count reflects it after edge N.
REQ-017 Full: push with fifo_count == FIFO_DEPTH and no pop in the same cycle SHALL be dropped and set overflow; a same-cycle pop SHALL make the push accepted.
REQ-018 FSM states: IDLE, ISSUE, WAIT_DONE; reset state IDLE.
REQ-019 IDLE with fifo_count > 0: pop head into the issue register; opcode 3'b000 (NOP) discarded, stay IDLE; opcode 3'b111 (FLUSH) clears the FIFO, stay IDLE; all others go to ISSUE.
REQ-020 FLUSH with a same-cycle push: FIFO cleared, then the incoming word stored, fifo_count = 1.
REQ-021 ISSUE: exec_valid = 1, exec_opcode/exec_operand stable from the issue register until exec_valid && exec_ready; then WAIT_DONE with exec_valid = 0 the next cycle.
REQ-022 WAIT_DONE: exec_done high returns to IDLE next cycle; exec_done outside WAIT_DONE is ignored.
REQ-023 Latency: instruction_valid at edge N into empty, IDLE block -> exec_valid high after edge N+2.
REQ-024 Back-to-back: exec_done at edge M with non-empty FIFO -> next exec_valid after edge M+2.
REQ-025 exec_opcode/exec_operand SHALL be 0 whenever exec_valid is 0.
REQ-026 Pushes SHALL be accepted in every state; ordering strictly FIFO.

Reset
REQ-027 reset high at a clock edge: state IDLE, FIFO emptied, pointers 0, fifo_count 0, exec_valid 0, exec_opcode 0, exec_operand 0, busy 0, overflow 0, timeout_err 0, timeout counter 0.
REQ-028 reset SHALL override any simultaneous push, pop, handshake or exec_done, including mid-ISSUE and mid-WAIT_DONE; no instruction survives reset.

Configuration
REQ-029 Macro CMD_TIMEOUT_EN defined: a counter clears on WAIT_DONE entry, increments each WAIT_DONE cycle; at TIMEOUT_CYCLES without exec_done set timeout_err and return to IDLE next cycle. exec_done on the terminal cycle wins (no error).
REQ-030 Macro CMD_TIMEOUT_EN undefined: no counter; WAIT_DONE waits indefinitely; timeout_err tied 0; port list unchanged.

Verification
REQ-031 Single issue: push 15'h5ABC, exec_ready = 1 -> exec_valid after 2 cycles, exec_opcode 3'b101, exec_operand 12'hABC; exec_done -> IDLE, busy 0.
REQ-032 Backpressure/order: push 15'h1001, 15'h2002, 15'h3003, exec_ready = 0 for 10 cycles -> operands stable, then issued 001, 002, 003 in order; fifo_count 2, 1, 0.
REQ-033 Overflow: FIFO_DEPTH = 4, hold in WAIT_DONE, push 6 words -> fifo_count 4, overflow = 1, fifth and sixth words never issued.
REQ-034 NOP/FLUSH: queue 15'h0123, 15'h7000, 15'h4444, 15'h7FFF, 15'h2222 -> only 15'h4444 issued; 15'h2222 cleared by FLUSH; fifo_count 0.
REQ-035 Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES = 16): issue, withhold exec_done -> timeout_err = 1 after 16 WAIT_DONE cycles, IDLE; without macro state remains WAIT_DONE, timeout_err 0.
REQ-036 Reset mid-op: reset in WAIT_DONE with 3 queued -> next cycle fifo_count 0, exec_valid 0, overflow/timeout_err 0, later exec_done ignored.

Source files
------------

// File: rtl/instruction_dispatcher.sv
// rtl/instruction_dispatcher.sv - queued instruction issue to an execution unit
// Optional WAIT_DONE watchdog enabled by defining CMD_TIMEOUT_EN.
module instruction_dispatcher #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] instruction_in,
    input  logic        instruction_valid,
    output logic [2:0]  exec_opcode,
    output logic [11:0] exec_operand,
    output logic        exec_valid,
    input  logic        exec_ready,
    input  logic        exec_done,
    output logic [4:0]  fifo_count,
    output logic        busy,
    output logic        overflow,
    output logic        timeout_err
);
    localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH    = 5'(FIFO_DEPTH);
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_FLUSH = 3'b111;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
    state_t state, state_next;

    logic [14:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, waddr;
    logic [4:0]    count;
    logic [14:0]   head;
    logic [14:0]   issue_reg;
    logic          armed;
    logic          pop, flush, push_ok, timed_out;

    assign head    = mem[rd_ptr];
    assign push_ok = instruction_valid && ((count != DEPTH) || pop);
    assign waddr   = flush ? '0 : wr_ptr;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        flush      = 1'b0;
        exec_valid = 1'b0;
        case (state)
            IDLE: begin
                if (count != 5'd0) begin
                    pop = 1'b1;
                    if (head[14:12] == OP_FLUSH)
                        flush = 1'b1;
                    else if (head[14:12] != OP_NOP)
                        state_next = ISSUE;
                end
            end
            ISSUE: begin
                // First ISSUE cycle only arms the request, giving the fixed two-edge latency.
                exec_valid = armed;
                if (armed && exec_ready)
                    state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (exec_done || timed_out)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            issue_reg <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_next;
            armed <= (state == ISSUE) && (state_next == ISSUE);
            if (pop && (state_next == ISSUE))
                issue_reg <= head;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= instruction_valid ? AW'(1) : '0;
                count  <= instruction_valid ? 5'd1 : 5'd0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + 5'(push_ok) - 5'(pop);
            end
            if (instruction_valid && !push_ok)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            mem[waddr] <= instruction_in;
    end

`ifdef CMD_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer;
    logic          timeout_q;

    // exec_done on the terminal cycle suppresses the error.
    assign timed_out   = (state == WAIT_DONE) && !exec_done && (timer == TMO_LAST);
    assign timeout_err = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer <= (state == WAIT_DONE) ? timer + 1'b1 : '0;
            if (timed_out)
                timeout_q <= 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    // Never set in this build; WAIT_DONE waits for exec_done indefinitely.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign exec_opcode  = exec_valid ? issue_reg[14:12] : 3'd0;
    assign exec_operand = exec_valid ? issue_reg[11:0] : 12'd0;
    assign fifo_count   = count;
    assign busy         = (state != IDLE) || (count != 5'd0);

endmodule
